// File: rtl/pipe_tracker.sv
// Per-stage valid/PC tracker for the five-stage pipeline, with saturating
// retire/stall/flush counters and a sticky ordering-error flag.
module pipe_tracker #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_rst,
  input  logic             id_rst,
  input  logic             exe_rst,
  input  logic             mem_rst,
  input  logic             wb_rst,
  input  logic             if_en,
  input  logic             id_en,
  input  logic             exe_en,
  input  logic             mem_en,
  input  logic             wb_en,
  input  logic [31:0]      pc_in,
  input  logic             cnt_clr,
  output logic             if_valid,
  output logic             id_valid,
  output logic             exe_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      id_pc,
  output logic [31:0]      exe_pc,
  output logic [31:0]      mem_pc,
  output logic [31:0]      wb_pc,
  output logic             retire,
  output logic [31:0]      retire_pc,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             order_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Index 0 is IF, 4 is WB.
  logic [4:0]  en_v;
  logic [4:0]  fl_v;
  logic [4:0]  adv_v;
  logic [4:0]  valid_q;
  logic [4:0]  prev_valid;
  logic [31:0] pc_q    [5];
  logic [31:0] prev_pc [5];

  logic [3:0]  kill_v;
  logic [3:0]  dup_v;
  logic [2:0]  flush_n;
  logic        stall_evt;
  logic        order_set;
  logic [CNT_W:0] flush_sum;

  assign en_v  = {wb_en, mem_en, exe_en, id_en, if_en};
  assign fl_v  = {wb_rst, mem_rst, exe_rst, id_rst, if_rst};
  assign adv_v = en_v & ~fl_v;

  assign prev_valid = {valid_q[3:0], 1'b1};

  always_comb begin
    prev_pc[0] = pc_in;
    for (int unsigned i = 1; i < 5; i++) begin
      prev_pc[i] = pc_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        pc_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (fl_v[i]) begin
          valid_q[i] <= 1'b0;
          pc_q[i]    <= '0;
        end else if (en_v[i]) begin
          valid_q[i] <= prev_valid[i];
          pc_q[i]    <= prev_pc[i];
        end
      end
    end
  end

  // Stage X (1..4) destroys the valid instruction still sitting in its predecessor.
  assign kill_v  = fl_v[4:1] & valid_q[3:0] & ~adv_v[3:0];
  assign flush_n = 3'(kill_v[0]) + 3'(kill_v[1]) + 3'(kill_v[2]) + 3'(kill_v[3]);

  // Predecessor holds a valid instruction while the successor loads a copy of it.
  assign dup_v     = valid_q[3:0] & ~en_v[3:0] & ~fl_v[3:0] & en_v[4:1] & ~fl_v[4:1];
  assign order_set = |dup_v;

  // A frozen IF counts only when some later stage keeps moving (not debug freeze).
  assign stall_evt = ~if_en & ~if_rst & (|en_v[4:1]);

  assign retire    = valid_q[4] & wb_en & ~wb_rst;
  assign retire_pc = pc_q[4];

  assign flush_sum = {1'b0, flush_cnt} + (CNT_W+1)'(flush_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      order_err  <= 1'b0;
    end else if (cnt_clr) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      order_err  <= 1'b0;
    end else begin
      if (retire && retire_cnt != CNT_MAX) retire_cnt <= retire_cnt + 1'b1;
      if (stall_evt && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (flush_sum[CNT_W]) flush_cnt <= CNT_MAX;
      else                  flush_cnt <= flush_sum[CNT_W-1:0];
      if (order_set) order_err <= 1'b1;
    end
  end

  assign if_valid  = valid_q[0];
  assign id_valid  = valid_q[1];
  assign exe_valid = valid_q[2];
  assign mem_valid = valid_q[3];
  assign wb_valid  = valid_q[4];
  assign if_pc     = pc_q[0];
  assign id_pc     = pc_q[1];
  assign exe_pc    = pc_q[2];
  assign mem_pc    = pc_q[3];
  assign wb_pc     = pc_q[4];

endmodule

// File: tb/tb_pipe_tracker.sv
// Bench for pipe_tracker: directed scenarios plus random stimulus against a
// per-cycle rule model of the stage contents and counters.
module tb_pipe_tracker;

  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en [5];
  logic          fl [5];
  logic [31:0]   pc_in;
  logic          cnt_clr;

  logic          if_valid, id_valid, exe_valid, mem_valid, wb_valid;
  logic [31:0]   if_pc, id_pc, exe_pc, mem_pc, wb_pc;
  logic          retire;
  logic [31:0]   retire_pc;
  logic [CW-1:0] retire_cnt, stall_cnt, flush_cnt;
  logic          order_err;

  logic [4:0]    dv;
  logic [31:0]   dpc [5];

  int total = 0;
  int bad   = 0;

  // Reference state: contents of each stage and plain integer counters.
  bit          m_v [5];
  logic [31:0] m_p [5];
  int          m_rc, m_sc, m_fc;
  bit          m_oe;

  pipe_tracker #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .if_rst(fl[0]), .id_rst(fl[1]), .exe_rst(fl[2]), .mem_rst(fl[3]), .wb_rst(fl[4]),
    .if_en(en[0]), .id_en(en[1]), .exe_en(en[2]), .mem_en(en[3]), .wb_en(en[4]),
    .pc_in(pc_in), .cnt_clr(cnt_clr),
    .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid),
    .if_pc(if_pc), .id_pc(id_pc), .exe_pc(exe_pc), .mem_pc(mem_pc), .wb_pc(wb_pc),
    .retire(retire), .retire_pc(retire_pc),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .order_err(order_err)
  );

  assign dv = {wb_valid, mem_valid, exe_valid, id_valid, if_valid};
  assign dpc[0] = if_pc;
  assign dpc[1] = id_pc;
  assign dpc[2] = exe_pc;
  assign dpc[3] = mem_pc;
  assign dpc[4] = wb_pc;

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int s = 0; s < 5; s++) begin
      m_v[s] = 1'b0;
      m_p[s] = 32'h0;
    end
    m_rc = 0; m_sc = 0; m_fc = 0; m_oe = 1'b0;
  endtask

  // e[0]/f[0] belong to IF, e[4]/f[4] to WB.
  task automatic set_inputs(input bit [4:0] e, input bit [4:0] f, input bit clr);
    for (int s = 0; s < 5; s++) begin
      en[s] = e[s];
      fl[s] = f[s];
    end
    cnt_clr = clr;
  endtask

  function automatic bit model_retire();
    return m_v[4] && en[4] && !fl[4];
  endfunction

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    bit          ret, stall, oset;
    int          nf;
    bit          nv [5];
    logic [31:0] np [5];
    ret   = model_retire();
    stall = !en[0] && !fl[0] && (en[1] || en[2] || en[3] || en[4]);
    nf    = 0;
    oset  = 1'b0;
    for (int x = 1; x < 5; x++) begin
      if (fl[x] && m_v[x-1] && !(en[x-1] && !fl[x-1])) nf++;
      if (m_v[x-1] && !en[x-1] && !fl[x-1] && en[x] && !fl[x]) oset = 1'b1;
    end
    for (int s = 0; s < 5; s++) begin
      nv[s] = m_v[s];
      np[s] = m_p[s];
      if (fl[s]) begin
        nv[s] = 1'b0;
        np[s] = 32'h0;
      end else if (en[s]) begin
        nv[s] = (s == 0) ? 1'b1  : m_v[s-1];
        np[s] = (s == 0) ? pc_in : m_p[s-1];
      end
    end
    for (int s = 0; s < 5; s++) begin
      m_v[s] = nv[s];
      m_p[s] = np[s];
    end
    if (cnt_clr) begin
      m_rc = 0; m_sc = 0; m_fc = 0; m_oe = 1'b0;
    end else begin
      m_rc = (m_rc + int'(ret)   > MAXC) ? MAXC : m_rc + int'(ret);
      m_sc = (m_sc + int'(stall) > MAXC) ? MAXC : m_sc + int'(stall);
      m_fc = (m_fc + nf          > MAXC) ? MAXC : m_fc + nf;
      m_oe = m_oe | oset;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_inputs(5'b11111, 5'b00000, 1'b0);
    pc_in = 32'h0;
    model_reset();
    #2;
    total++;
    if (dv !== 5'b0 || retire !== 1'b0 || retire_pc !== 32'h0) begin
      bad++; $display("FAIL reset_valid: got valid=%b retire=%b rpc=%h, want 0", dv, retire, retire_pc);
    end
    total++;
    if (retire_cnt !== '0 || stall_cnt !== '0 || flush_cnt !== '0 || order_err !== 1'b0) begin
      bad++; $display("FAIL reset_cnt: got r=%0d s=%0d f=%0d oe=%b, want 0", retire_cnt, stall_cnt, flush_cnt, order_err);
    end
  endtask

  task automatic test_fill();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 7; k++) begin
      pc_in = 32'(4 * k);
      tick();
      if (k == 4) begin
        total++;
        if (wb_valid !== 1'b1 || wb_pc !== 32'h0) begin
          bad++; $display("FAIL fill_wb: got v=%b pc=%h, want v=1 pc=00000000", wb_valid, wb_pc);
        end
      end
    end
    total++;
    if (retire_cnt !== CW'(m_rc)) begin
      bad++; $display("FAIL fill_retire_cnt: got %0d, want %0d", retire_cnt, m_rc);
    end
  endtask

  task automatic test_load_use();
    rst = 1'b0; #1; rst = 1'b1;
    model_reset();
    set_inputs(5'b11111, 5'b00000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      pc_in = 32'(4 * k);
      tick();
    end
    pc_in = 32'h18;
    set_inputs(5'b11100, 5'b00100, 1'b0);
    tick();
    total++;
    if (if_pc !== 32'h14 || id_pc !== 32'h10 || if_valid !== 1'b1 || id_valid !== 1'b1) begin
      bad++; $display("FAIL lu_hold: got if=%h id=%h, want if=00000014 id=00000010", if_pc, id_pc);
    end
    total++;
    if (exe_valid !== 1'b0 || exe_pc !== 32'h0) begin
      bad++; $display("FAIL lu_bubble: got v=%b pc=%h, want 0", exe_valid, exe_pc);
    end
    total++;
    if (stall_cnt !== CW'(m_sc) || m_sc != 1 || order_err !== 1'b0) begin
      bad++; $display("FAIL lu_stall: got stall=%0d oe=%b, want stall=1 oe=0", stall_cnt, order_err);
    end
    total++;
    if (flush_cnt !== CW'(m_fc)) begin
      bad++; $display("FAIL lu_flush: got %0d, want %0d", flush_cnt, m_fc);
    end
  endtask

  task automatic test_branch_flush();
    int fc0;
    fc0 = int'(flush_cnt);
    set_inputs(5'b11110, 5'b00010, 1'b0);
    tick();
    total++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0) begin
      bad++; $display("FAIL br_id: got v=%b pc=%h, want 0", id_valid, id_pc);
    end
    total++;
    if (int'(flush_cnt) !== fc0 + 1 || flush_cnt !== CW'(m_fc)) begin
      bad++; $display("FAIL br_flush_cnt: got %0d, want %0d", flush_cnt, fc0 + 1);
    end
    set_inputs(5'b11111, 5'b00000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      pc_in = pc_in + 32'h4;
      tick();
    end
    total++;
    if (wb_valid !== 1'b0 || retire !== 1'b0 || retire !== model_retire()) begin
      bad++; $display("FAIL br_bubble_wb: got wb_v=%b retire=%b, want 0", wb_valid, retire);
    end
  endtask

  task automatic test_order_err();
    set_inputs(5'b11101, 5'b00000, 1'b0);
    tick();
    total++;
    if (order_err !== 1'b1 || m_oe != 1'b1) begin
      bad++; $display("FAIL oe_set: got %b, want 1", order_err);
    end
    set_inputs(5'b11111, 5'b00000, 1'b0);
    tick();
    total++;
    if (order_err !== 1'b1) begin
      bad++; $display("FAIL oe_sticky: got %b, want 1", order_err);
    end
    set_inputs(5'b11111, 5'b00000, 1'b1);
    tick();
    total++;
    if (order_err !== 1'b0 || retire_cnt !== '0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      bad++; $display("FAIL oe_clr: got oe=%b r=%0d s=%0d f=%0d, want 0", order_err, retire_cnt, stall_cnt, flush_cnt);
    end
    set_inputs(5'b11101, 5'b00000, 1'b1);
    tick();
    total++;
    if (order_err !== 1'b0) begin
      bad++; $display("FAIL oe_clr_wins: got %b, want 0", order_err);
    end
  endtask

  task automatic test_saturation();
    set_inputs(5'b11111, 5'b00000, 1'b0);
    for (int k = 0; k < 24; k++) begin
      pc_in = pc_in + 32'h4;
      tick();
    end
    total++;
    if (retire_cnt !== 4'd15 || retire_cnt !== CW'(m_rc)) begin
      bad++; $display("FAIL sat_hold: got %0d, want 15", retire_cnt);
    end
    set_inputs(5'b11111, 5'b00000, 1'b1);
    #1;
    total++;
    if (retire !== 1'b1 || retire_pc !== m_p[4]) begin
      bad++; $display("FAIL sat_retire: got %b pc=%h, want 1 pc=%h", retire, retire_pc, m_p[4]);
    end
    tick();
    total++;
    if (retire_cnt !== '0) begin
      bad++; $display("FAIL sat_clr: got %0d, want 0", retire_cnt);
    end
  endtask

  task automatic test_random();
    bit [4:0] e, f;
    bit       clr;
    for (int k = 0; k < 400; k++) begin
      for (int s = 0; s < 5; s++) begin
        e[s] = ($urandom_range(7) != 0);
        f[s] = ($urandom_range(15) == 0);
      end
      if ($urandom_range(31) == 0) e = 5'b0;
      clr   = ($urandom_range(31) == 0);
      pc_in = {$urandom_range(32'h3FFF_FFFF), 2'b00};
      set_inputs(e, f, clr);
      #1;
      total++;
      if (retire !== model_retire() || retire_pc !== m_p[4]) begin
        bad++; $display("FAIL rnd_retire[%0d]: got %b/%h, want %b/%h", k, retire, retire_pc, model_retire(), m_p[4]);
      end
      tick();
      total++;
      if (dv !== {m_v[4], m_v[3], m_v[2], m_v[1], m_v[0]} || dpc[0] !== m_p[0] || dpc[1] !== m_p[1]
          || dpc[2] !== m_p[2] || dpc[3] !== m_p[3] || dpc[4] !== m_p[4]) begin
        bad++; $display("FAIL rnd_stages[%0d]: got v=%b wb_pc=%h, want v=%b wb_pc=%h", k, dv, wb_pc,
                        {m_v[4], m_v[3], m_v[2], m_v[1], m_v[0]}, m_p[4]);
      end
      total++;
      if (retire_cnt !== CW'(m_rc) || stall_cnt !== CW'(m_sc) || flush_cnt !== CW'(m_fc) || order_err !== m_oe) begin
        bad++; $display("FAIL rnd_cnt[%0d]: got r=%0d s=%0d f=%0d oe=%b, want r=%0d s=%0d f=%0d oe=%b", k,
                        retire_cnt, stall_cnt, flush_cnt, order_err, m_rc, m_sc, m_fc, m_oe);
      end
    end
  endtask

  task automatic test_async_reset();
    set_inputs(5'b11111, 5'b00000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      pc_in = 32'h100 + 32'(4 * k);
      tick();
    end
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    total++;
    if (dv !== 5'b0 || if_pc !== 32'h0 || id_pc !== 32'h0 || exe_pc !== 32'h0
        || mem_pc !== 32'h0 || wb_pc !== 32'h0 || retire !== 1'b0) begin
      bad++; $display("FAIL arst_stages: got v=%b wb_pc=%h retire=%b, want 0", dv, wb_pc, retire);
    end
    total++;
    if (retire_cnt !== '0 || stall_cnt !== '0 || flush_cnt !== '0 || order_err !== 1'b0) begin
      bad++; $display("FAIL arst_cnt: got r=%0d s=%0d f=%0d oe=%b, want 0", retire_cnt, stall_cnt, flush_cnt, order_err);
    end
    rst   = 1'b1;
    pc_in = 32'h200;
    tick();
    total++;
    if (dv !== 5'b00001 || if_pc !== 32'h200) begin
      bad++; $display("FAIL arst_restart: got v=%b if_pc=%h, want 00001/00000200", dv, if_pc);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_load_use();
    test_branch_flush();
    test_order_err();
    test_saturation();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
